// File: rtl/lzw_pkg.sv
// rtl/lzw_pkg.sv - shared types and constants for the LZW job arbiter slice
package lzw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        DRAIN,
        ABORT
    } arb_state_t;

    localparam int BYTE_W    = 8;
    localparam int CODE_W    = 12;
    localparam int DICT_INIT = 256;

endpackage

// File: rtl/lzw_rr_pick.sv
// rtl/lzw_rr_pick.sv - combinational round-robin picker
// Searches upward from ptr_i+1 with wrap-around and returns the first set request.
module lzw_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(ptr_i) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o             = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lzw_job_arbiter.sv
// rtl/lzw_job_arbiter.sv - round-robin per-message arbiter feeding one LZW core
// Optional stall watchdog with ABORT state: define LZW_ARB_WATCHDOG_EN.
module lzw_job_arbiter
    import lzw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          byte_valid_i,
    input  logic [NUM_REQ*BYTE_W-1:0]   byte_i,
    input  logic [NUM_REQ-1:0]          byte_last_i,
    output logic [NUM_REQ-1:0]          byte_ready_o,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic [NUM_REQ-1:0]          err_o,
    output logic                        core_start_o,
    output logic                        core_valid_o,
    output logic [BYTE_W-1:0]           core_byte_o,
    output logic                        core_last_o,
    input  logic                        core_ready_i,
    input  logic                        core_done_i,
    output logic                        core_abort_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("lzw_job_arbiter: NUM_REQ or TIMEOUT out of range");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [BYTE_W-1:0]  byte_arr [NUM_REQ];
    logic               own_valid;
    logic               own_last;
    logic [BYTE_W-1:0]  own_byte;
    logic               stall_hit;

    lzw_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign byte_arr[g] = byte_i[g*BYTE_W +: BYTE_W];
    end

    assign own_valid = byte_valid_i[owner_q];
    assign own_last  = byte_last_i[owner_q];
    assign own_byte  = byte_arr[owner_q];

`ifdef LZW_ARB_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0] stall_q, stall_d;

    // Only a silent owner counts; back-pressure from the core is not a stall.
    always_comb begin
        stall_d   = '0;
        stall_hit = 1'b0;
        if (state_q == STREAM) begin
            stall_d = stall_q;
            if (own_valid && core_ready_i) begin
                stall_d = '0;
            end else if (!own_valid) begin
                stall_d   = stall_q + 8'd1;
                stall_hit = (stall_d == TIMEOUT_C);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        byte_ready_o = '0;
        err_o        = '0;
        core_start_o = 1'b0;
        core_valid_o = 1'b0;
        core_byte_o  = '0;
        core_last_o  = 1'b0;
        core_abort_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = START;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                end
            end
            START: begin
                core_start_o = 1'b1;
                state_d      = STREAM;
            end
            STREAM: begin
                core_valid_o          = own_valid;
                core_byte_o           = own_byte;
                core_last_o           = own_last;
                byte_ready_o[owner_q] = core_ready_i;
                if (own_valid && core_ready_i && own_last) begin
                    state_d = DRAIN;
                end else if (stall_hit) begin
                    state_d = ABORT;
                end
            end
            DRAIN: begin
                if (core_done_i) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q;
                    grant_d  = '0;
                end
            end
`ifdef LZW_ARB_WATCHDOG_EN
            ABORT: begin
                core_abort_o = 1'b1;
                err_o        = grant_q;
                state_d      = IDLE;
                rr_ptr_d     = owner_q;
                grant_d      = '0;
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_o = grant_q;
    assign owner_o = owner_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_lzw_job_arbiter.sv
// tb/tb_lzw_job_arbiter.sv - scoreboard bench for lzw_job_arbiter
module tb_lzw_job_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic [3:0]  byte_valid_i;
    logic [31:0] byte_i;
    logic [3:0]  byte_last_i;
    logic [3:0]  byte_ready_o;
    logic [3:0]  grant_o;
    logic [3:0]  err_o;
    logic        core_start_o;
    logic        core_valid_o;
    logic [7:0]  core_byte_o;
    logic        core_last_o;
    logic        core_ready_i;
    logic        core_done_i;
    logic        core_abort_o;
    logic [1:0]  owner_o;
    logic        busy_o;

    lzw_job_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .req_i        (req_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_last_i  (byte_last_i),
        .byte_ready_o (byte_ready_o),
        .grant_o      (grant_o),
        .err_o        (err_o),
        .core_start_o (core_start_o),
        .core_valid_o (core_valid_o),
        .core_byte_o  (core_byte_o),
        .core_last_o  (core_last_o),
        .core_ready_i (core_ready_i),
        .core_done_i  (core_done_i),
        .core_abort_o (core_abort_o),
        .owner_o      (owner_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q [$];
    logic [3:0]  gnt_q [$];
    logic [7:0]  msg_buf [0:15];
    logic        watch_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on every core-side handshake and every start pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_valid_o && core_ready_i) begin
                if (exp_q.size() == 0) chk("byte_unexpected", {owner_o, core_byte_o, core_last_o}, 32'hFFFF);
                else chk("core_byte", {owner_o, core_byte_o, core_last_o}, exp_q.pop_front());
            end
            if (core_start_o) begin
                chk("grant_onehot", $countones(grant_o), 1);
                if (gnt_q.size() == 0) chk("grant_unexpected", grant_o, 0);
                else chk("grant", grant_o, gnt_q.pop_front());
            end
            if (watch_en) chk("nonowner_ready", byte_ready_o[3], 0);
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        req_i        = '0;
        byte_valid_i = '0;
        byte_i       = '0;
        byte_last_i  = '0;
        core_ready_i = 1'b1;
        core_done_i  = 1'b0;
        exp_q.delete();
        gnt_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_msg(input logic [7:0] base);
        for (int i = 0; i < 16; i++) msg_buf[i] = base + 8'(i);
    endtask

    task automatic send_msg(input int r, input int off, input int n, input bit with_last);
        int  k;
        int  budget;
        bit  acc;
        for (int i = 0; i < n; i++)
            exp_q.push_back({2'(r), msg_buf[off+i], with_last && (i == n - 1)});
        k      = 0;
        budget = 100;
        while (k < n) begin
            byte_valid_i[r]       = 1'b1;
            byte_i[r*8 +: 8]      = msg_buf[off+k];
            byte_last_i[r]        = with_last && (k == n - 1);
            @(negedge clk);
            acc = byte_ready_o[r];
            @(posedge clk);
            #1;
            if (acc) k++;
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 1, 0);
                k = n;
            end
        end
        byte_valid_i[r] = 1'b0;
        byte_last_i[r]  = 1'b0;
    endtask

    task automatic finish_job(input logic [3:0] exp_grant);
        @(negedge clk);
        chk("drain_valid", core_valid_o, 0);
        chk("drain_ready", byte_ready_o, 0);
        chk("drain_grant", grant_o, exp_grant);
        @(posedge clk);
        #1 core_done_i = 1'b1;
        @(posedge clk);
        #1 core_done_i = 1'b0;
        chk("done_idle", {busy_o, grant_o}, 0);
    endtask

    initial begin
        string s;
        bit    ok;
        int    order [5];
        order = '{0, 1, 2, 3, 0};

        // Reset state, then one 14-byte message from requester 2
        do_reset();
        chk("rst_outputs", {grant_o, byte_ready_o, err_o, core_start_o, core_valid_o,
                            core_abort_o, owner_o, busy_o}, 0);
        s = "banana_bandana";
        for (int i = 0; i < 14; i++) msg_buf[i] = s[i];
        gnt_q.push_back(4'b0100);
        req_i = 4'b0100;
        @(posedge clk);
        #1;
        chk("start_latency", {grant_o, core_start_o, busy_o}, {4'b0100, 1'b1, 1'b1});
        req_i = '0;
        send_msg(2, 0, 14, 1);
        finish_job(4'b0100);

        // All requesters pending: order 0,1,2,3,0
        do_reset();
        req_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            fill_msg(8'(8'h10 * (j + 1)));
            gnt_q.push_back(4'(1 << order[j]));
            send_msg(order[j], 0, 3, 1);
            if (j == 4) req_i = '0;
            finish_job(4'(1 << order[j]));
        end

        // Owner drops request mid-message; non-owner shouts
        do_reset();
        fill_msg(8'h40);
        gnt_q.push_back(4'b0010);
        req_i            = 4'b1010;
        byte_valid_i[3]  = 1'b1;
        byte_i[31:24]    = 8'hEE;
        byte_last_i[3]   = 1'b1;
        watch_en         = 1'b1;
        fork
            send_msg(1, 0, 5, 1);
            begin
                repeat (3) @(posedge clk);
                #1 req_i[1] = 1'b0;
            end
        join
        req_i[3] = 1'b0;
        finish_job(4'b0010);
        watch_en        = 1'b0;
        byte_valid_i[3] = 1'b0;
        byte_last_i[3]  = 1'b0;

        // Core back-pressure 1,0,0,1
        do_reset();
        fill_msg(8'h60);
        gnt_q.push_back(4'b0001);
        req_i = 4'b0001;
        fork
            send_msg(0, 0, 4, 1);
            begin
                logic [3:0] pat;
                pat = 4'b1001;
                repeat (2) @(posedge clk);
                for (int i = 3; i >= 0; i--) begin
                    #1 core_ready_i = pat[i];
                    @(negedge clk);
                    chk("ready_mirror", byte_ready_o, {3'b000, pat[i]});
                    @(posedge clk);
                end
                #1 core_ready_i = 1'b1;
            end
        join
        req_i = '0;
        finish_job(4'b0001);

        // Spurious core_done during STREAM
        do_reset();
        fill_msg(8'h80);
        gnt_q.push_back(4'b1000);
        req_i = 4'b1000;
        fork
            send_msg(3, 0, 6, 1);
            begin
                repeat (3) @(posedge clk);
                #1 core_done_i = 1'b1;
                @(posedge clk);
                #1 core_done_i = 1'b0;
                chk("done_ignored", {busy_o, grant_o}, {1'b1, 4'b1000});
            end
        join
        req_i = '0;
        finish_job(4'b1000);

        // Owner goes silent after 2 bytes
        do_reset();
        fill_msg(8'hA0);
        gnt_q.push_back(4'b0100);
        req_i = 4'b0100;
        send_msg(2, 0, 2, 0);
        req_i = '0;
`ifdef LZW_ARB_WATCHDOG_EN
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8 && core_abort_o) ok = 1'b0;
            if (i == 8) chk("abort_pulse", {core_abort_o, err_o}, {1'b1, 4'b0100});
            if (i == 9) chk("abort_idle", {core_abort_o, err_o, busy_o, grant_o}, 0);
        end
        chk("abort_not_early", ok, 1);
        @(posedge clk);
        #1;
`else
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy_o || grant_o != 4'b0100 || core_abort_o || err_o != 0) ok = 1'b0;
        end
        chk("stall_held", ok, 1);
        @(posedge clk);
        #1;
        send_msg(2, 2, 1, 1);
        finish_job(4'b0100);
`endif

        // Asynchronous reset in the middle of a job
        do_reset();
        gnt_q.push_back(4'b0001);
        req_i = 4'b0001;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {busy_o, grant_o, core_start_o, core_abort_o}, 0);
        req_i = '0;
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (3) @(posedge clk);
        chk("bytes_left", exp_q.size(), 0);
        chk("grants_left", gnt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
